serial_word_deser: RTL and testbench

Receive-side deserializer placed directly downstream of the serial word transmitter. It watches the transmitter's frame-enable and serial data lines, rebuilds each W-bit word (LSB first), and buffers completed words in a small FIFO. The FIFO drives a ready/valid interface to the consumer. Malformed frames are counted and discarded; buffer overruns are flagged.

---
 rtl/serial_word_deser_pkg.sv | 17 +
 rtl/serial_word_deser_if.sv | 21 ++
 rtl/deser_sync_fifo.sv | 76 +++++++
 rtl/serial_word_deser.sv | 114 +++++++++++
 tb/tb_serial_word_deser.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_word_deser_pkg.sv
// Shared types and defaults for the serial word deserializer.
// Holds the receive FSM state type, default word width / FIFO depth,
// and the widths of the statistics counters.
package serial_deser_pkg;

   localparam int unsigned DESER_W     = 10;
   localparam int unsigned DESER_DEPTH = 4;
   localparam int unsigned FRAME_CNT_W = 16;
   localparam int unsigned ERR_CNT_W   = 8;

   typedef enum logic [1:0] {
      WAIT_HI,
      WAIT_LO,
      SHIFT
   } deser_state_e;

endpackage

// File: rtl/serial_word_deser_if.sv
// Bus bundle for the deserializer.
// Serial side:   ena_i (high = idle, low = frame), data_i (LSB first).
// Consumer side: word_o / valid_o with ready_i acceptance.
// slave  : deserializer view (receives serial + ready, drives word/valid).
// master : transmitter/consumer view.
interface serial_word_deser_if
   import serial_deser_pkg::*;
#(
   parameter int unsigned W = DESER_W
) ();

   logic         ena_i;
   logic         data_i;
   logic         ready_i;
   logic [W-1:0] word_o;
   logic         valid_o;

   modport slave  (input  ena_i, data_i, ready_i, output word_o, valid_o);
   modport master (output ena_i, data_i, ready_i, input  word_o, valid_o);

endinterface

// File: rtl/deser_sync_fifo.sv
// Synchronous FIFO with registered head-of-queue output.
// Ports:
//   clk_i, rst_i   : clock, asynchronous active-low reset
//   push_i, din_i  : write request / data (write while full is allowed only
//                    together with an effective pop)
//   pop_i          : read request, ignored while empty
//   dout_o         : registered head word
//   full_o, empty_o: status; empty_o is registered alongside dout_o
module deser_sync_fifo #(
   parameter int unsigned WIDTH = 10,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             empty_q, empty_d;
   logic             do_push, do_pop;

   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty_o = empty_q;
   assign dout_o  = dout_q;

   assign do_pop  = pop_i & ~empty_q;
   assign do_push = push_i & (~full_o | do_pop);

   // The head register is precomputed from the post-edge pointers; a word
   // written into the slot that becomes the head bypasses the memory.
   always_comb begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
      rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
      empty_d  = (wr_ptr_d == rd_ptr_d);
      dout_d   = dout_q;
      if (!empty_d) begin
         if (do_push && (rd_ptr_d == wr_ptr_q)) begin
            dout_d = din_i;
         end else begin
            dout_d = mem_q[rd_ptr_d[AW-1:0]];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         dout_q   <= '0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         dout_q   <= dout_d;
         empty_q  <= empty_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= din_i;
      end
   end

endmodule

// File: rtl/serial_word_deser.sv
// Serial word deserializer: rebuilds W-bit LSB-first frames framed by a
// low ena_i, buffers them in a FIFO and presents them on a ready/valid bus.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-low reset
//   bus          : serial inputs and consumer handshake (slave modport)
//   overflow_o   : sticky, a complete word was dropped on a full FIFO
//   frame_cnt_o  : words written into the FIFO (wrapping)
//   err_cnt_o    : truncated frames (saturating)
module serial_word_deser
   import serial_deser_pkg::*;
#(
   parameter int unsigned W     = DESER_W,
   parameter int unsigned DEPTH = DESER_DEPTH
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   serial_word_deser_if.slave     bus,
   output logic                   overflow_o,
   output logic [FRAME_CNT_W-1:0] frame_cnt_o,
   output logic [ERR_CNT_W-1:0]   err_cnt_o
);

   localparam int unsigned CNT_W = $clog2(W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

   deser_state_e           state_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [W-2:0]           shreg_q;
   logic [W-1:0]           pword_q;
   logic                   push_q;
   logic [FRAME_CNT_W-1:0] frame_cnt_q;
   logic [ERR_CNT_W-1:0]   err_cnt_q;
   logic                   overflow_q;
   logic                   fifo_full, fifo_empty, pop;

   assign pop         = bus.ready_i & ~fifo_empty;
   assign bus.valid_o = ~fifo_empty;
   assign overflow_o  = overflow_q;
   assign frame_cnt_o = frame_cnt_q;
   assign err_cnt_o   = err_cnt_q;

   // Bits enter at the top and shift right, so after W-1 samples bit 0 sits
   // at shreg_q[0]; the final bit is appended directly as the word MSB.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= WAIT_HI;
         cnt_q     <= '0;
         shreg_q   <= '0;
         pword_q   <= '0;
         push_q    <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         push_q <= 1'b0;
         case (state_q)
            WAIT_HI: begin
               if (bus.ena_i) state_q <= WAIT_LO;
            end
            WAIT_LO: begin
               if (!bus.ena_i) begin
                  shreg_q <= {bus.data_i, shreg_q[W-2:1]};
                  cnt_q   <= CNT_W'(1);
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               if (bus.ena_i) begin
                  // Truncated frame; the idle-high just seen arms WAIT_LO.
                  if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
                  cnt_q   <= '0;
                  state_q <= WAIT_LO;
               end else if (cnt_q == CNT_LAST) begin
                  pword_q <= {bus.data_i, shreg_q};
                  push_q  <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= WAIT_HI;
               end else begin
                  shreg_q <= {bus.data_i, shreg_q[W-2:1]};
                  cnt_q   <= cnt_q + CNT_W'(1);
               end
            end
            default: state_q <= WAIT_HI;
         endcase
      end
   end

   // A push on a full FIFO survives only if a pop frees a slot on that edge.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         frame_cnt_q <= '0;
         overflow_q  <= 1'b0;
      end else if (push_q) begin
         if (!fifo_full || pop) begin
            frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
         end else begin
            overflow_q <= 1'b1;
         end
      end
   end

   deser_sync_fifo #(
      .WIDTH (W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push_q),
      .pop_i   (pop),
      .din_i   (pword_q),
      .dout_o  (bus.word_o),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

endmodule

// File: tb/tb_serial_word_deser.sv
module tb_serial_word_deser;
   import serial_deser_pkg::*;

   localparam int unsigned W     = 10;
   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        overflow;
   logic [15:0] frame_cnt;
   logic [7:0]  err_cnt;

   serial_word_deser_if #(.W(W)) bus ();

   serial_word_deser #(.W(W), .DEPTH(DEPTH)) dut (
      .clk_i       (clk),
      .rst_i       (rst_n),
      .bus         (bus),
      .overflow_o  (overflow),
      .frame_cnt_o (frame_cnt),
      .err_cnt_o   (err_cnt)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // Reference: words the consumer should see, in order, versus words it saw.
   logic [W-1:0] exp_q[$];
   logic [W-1:0] got_q[$];

   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.valid_o === 1'b1 && bus.ready_i === 1'b1)
         got_q.push_back(bus.word_o);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      bus.ena_i   = 1'b1;
      bus.data_i  = 1'b0;
      bus.ready_i = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic send_frame(input logic [W-1:0] v, input int unsigned gap);
      bus.ena_i  = 1'b1;
      bus.data_i = 1'b0;
      repeat (gap) tick();
      for (int unsigned k = 0; k < W; k++) begin
         bus.ena_i  = 1'b0;
         bus.data_i = v[k];
         tick();
      end
      bus.ena_i  = 1'b1;
      bus.data_i = 1'b0;
   endtask

   task automatic wait_got(input int unsigned n);
      int unsigned budget;
      budget = 0;
      while (got_q.size() < n && budget < 300) begin
         tick();
         budget++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; bus.ena_i = 1'b1; bus.data_i = 1'b0; bus.ready_i = 1'b0;
      repeat (2) tick();
      n_checks++; if (bus.word_o !== '0) begin n_errors++; $display("FAIL rst_word: got %0h expected 0", bus.word_o); end
      n_checks++; if (bus.valid_o !== 1'b0) begin n_errors++; $display("FAIL rst_valid: got %0b expected 0", bus.valid_o); end
      n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL rst_ovf: got %0b expected 0", overflow); end
      n_checks++; if (frame_cnt !== 16'd0) begin n_errors++; $display("FAIL rst_frame: got %0d expected 0", frame_cnt); end
      n_checks++; if (err_cnt !== 8'd0) begin n_errors++; $display("FAIL rst_err: got %0d expected 0", err_cnt); end
   endtask

   task automatic test_single_frame();
      do_reset();
      bus.ready_i = 1'b1;
      exp_q.push_back(10'd6);
      send_frame(10'd6, 1);
      n_checks++; if (bus.valid_o !== 1'b0) begin n_errors++; $display("FAIL single_lat_early: valid got %0b expected 0", bus.valid_o); end
      tick();
      n_checks++; if (bus.valid_o !== 1'b1) begin n_errors++; $display("FAIL single_valid: got %0b expected 1", bus.valid_o); end
      n_checks++; if (bus.word_o !== 10'd6) begin n_errors++; $display("FAIL single_word: got %0d expected 6", bus.word_o); end
      n_checks++; if (frame_cnt !== 16'd1) begin n_errors++; $display("FAIL single_frame_cnt: got %0d expected 1", frame_cnt); end
      n_checks++; if (err_cnt !== 8'd0) begin n_errors++; $display("FAIL single_err_cnt: got %0d expected 0", err_cnt); end
      wait_got(1);
      repeat (2) tick();
      n_checks++; if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin n_errors++; $display("FAIL single_rx: got %0d words expected 1 word of 6", got_q.size()); end
   endtask

   task automatic test_burst();
      logic [W-1:0] v;
      do_reset();
      bus.ready_i = 1'b1;
      for (int i = 0; i < 100; i++) begin
         v = W'($urandom);
         exp_q.push_back(v);
         send_frame(v, $urandom_range(20, 10));
      end
      wait_got(100);
      repeat (3) tick();
      n_checks++; if (got_q.size() != 100) begin n_errors++; $display("FAIL burst_count: got %0d expected 100", got_q.size()); end
      for (int i = 0; i < 100 && i < got_q.size(); i++) begin
         n_checks++; if (got_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL burst_word[%0d]: got %0h expected %0h", i, got_q[i], exp_q[i]); end
      end
      n_checks++; if (frame_cnt !== 16'd100) begin n_errors++; $display("FAIL burst_frame_cnt: got %0d expected 100", frame_cnt); end
      n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL burst_ovf: got %0b expected 0", overflow); end
   endtask

   task automatic test_truncated();
      do_reset();
      bus.ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.ena_i  = 1'b0;
         bus.data_i = 1'($urandom);
         tick();
      end
      exp_q.push_back(10'h3FF);
      send_frame(10'h3FF, 1);
      tick();
      wait_got(1);
      repeat (3) tick();
      n_checks++; if (err_cnt !== 8'd1) begin n_errors++; $display("FAIL trunc_err_cnt: got %0d expected 1", err_cnt); end
      n_checks++; if (got_q.size() != 1) begin n_errors++; $display("FAIL trunc_count: got %0d expected 1", got_q.size()); end
      n_checks++; if (got_q.size() > 0 && got_q[0] !== exp_q[0]) begin n_errors++; $display("FAIL trunc_word: got %0h expected 3ff", got_q[0]); end
      n_checks++; if (frame_cnt !== 16'd1) begin n_errors++; $display("FAIL trunc_frame_cnt: got %0d expected 1", frame_cnt); end
   endtask

   task automatic test_overflow();
      do_reset();
      bus.ready_i = 1'b0;
      for (int unsigned v = 1; v <= 5; v++) begin
         if (v <= DEPTH) exp_q.push_back(W'(v));
         send_frame(W'(v), 2);
      end
      tick();
      n_checks++; if (overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_flag: got %0b expected 1", overflow); end
      n_checks++; if (bus.word_o !== 10'd1) begin n_errors++; $display("FAIL ovf_head: got %0d expected 1", bus.word_o); end
      n_checks++; if (frame_cnt !== 16'd4) begin n_errors++; $display("FAIL ovf_frame_cnt: got %0d expected 4", frame_cnt); end
      bus.ready_i = 1'b1;
      wait_got(4);
      repeat (3) tick();
      n_checks++; if (got_q.size() != 4) begin n_errors++; $display("FAIL ovf_drain_count: got %0d expected 4", got_q.size()); end
      for (int i = 0; i < 4 && i < got_q.size(); i++) begin
         n_checks++; if (got_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL ovf_word[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]); end
      end
      n_checks++; if (bus.valid_o !== 1'b0) begin n_errors++; $display("FAIL ovf_empty: valid got %0b expected 0", bus.valid_o); end
      n_checks++; if (overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_sticky: got %0b expected 1", overflow); end
   endtask

   task automatic test_full_push_pop();
      logic [W-1:0] v;
      do_reset();
      bus.ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         v = W'($urandom);
         exp_q.push_back(v);
         send_frame(v, 2);
      end
      // FIFO holds four words; the fifth is pushed on the next edge with a pop.
      bus.ready_i = 1'b1;
      tick();
      bus.ready_i = 1'b0;
      n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL fpp_ovf: got %0b expected 0", overflow); end
      n_checks++; if (frame_cnt !== 16'd5) begin n_errors++; $display("FAIL fpp_frame_cnt: got %0d expected 5", frame_cnt); end
      n_checks++; if (bus.word_o !== exp_q[1]) begin n_errors++; $display("FAIL fpp_head: got %0h expected %0h", bus.word_o, exp_q[1]); end
      bus.ready_i = 1'b1;
      wait_got(5);
      repeat (3) tick();
      n_checks++; if (got_q.size() != 5) begin n_errors++; $display("FAIL fpp_count: got %0d expected 5", got_q.size()); end
      for (int i = 0; i < 5 && i < got_q.size(); i++) begin
         n_checks++; if (got_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL fpp_word[%0d]: got %0h expected %0h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [W-1:0] v;
      do_reset();
      bus.ready_i = 1'b0;
      send_frame(W'($urandom_range(1023, 1)), 1);
      tick();
      v = W'($urandom);
      bus.ena_i = 1'b1;
      tick();
      for (int unsigned k = 0; k < 6; k++) begin
         bus.ena_i  = 1'b0;
         bus.data_i = v[k];
         tick();
      end
      rst_n = 1'b0;
      #1;
      n_checks++; if (bus.word_o !== '0) begin n_errors++; $display("FAIL mid_rst_word: got %0h expected 0", bus.word_o); end
      n_checks++; if (bus.valid_o !== 1'b0) begin n_errors++; $display("FAIL mid_rst_valid: got %0b expected 0", bus.valid_o); end
      n_checks++; if (frame_cnt !== 16'd0) begin n_errors++; $display("FAIL mid_rst_frame: got %0d expected 0", frame_cnt); end
      n_checks++; if (overflow !== 1'b0 || err_cnt !== 8'd0) begin n_errors++; $display("FAIL mid_rst_stats: ovf %0b err %0d expected 0 0", overflow, err_cnt); end
      tick();
      // Release with ena low: these bits must not form a word.
      bus.ena_i = 1'b0;
      rst_n = 1'b1;
      for (int unsigned k = 0; k < W; k++) begin
         bus.data_i = 1'($urandom);
         tick();
      end
      got_q.delete();
      exp_q.delete();
      bus.ready_i = 1'b1;
      exp_q.push_back(10'd9);
      send_frame(10'd9, 1);
      tick();
      wait_got(1);
      repeat (3) tick();
      n_checks++; if (got_q.size() != 1) begin n_errors++; $display("FAIL mid_count: got %0d expected 1", got_q.size()); end
      n_checks++; if (got_q.size() > 0 && got_q[0] !== exp_q[0]) begin n_errors++; $display("FAIL mid_word: got %0d expected 9", got_q[0]); end
      n_checks++; if (frame_cnt !== 16'd1) begin n_errors++; $display("FAIL mid_frame_cnt: got %0d expected 1", frame_cnt); end
      n_checks++; if (err_cnt !== 8'd0) begin n_errors++; $display("FAIL mid_err_cnt: got %0d expected 0", err_cnt); end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_burst();
      test_truncated();
      test_overflow();
      test_full_push_pop();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
